mem_stage: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline, sitting between the EX/MEM pipeline register and the writeback stage. It performs word loads and stores against an internal data memory of configurable latency and drives the MEM/WB pipeline register consumed by writeback: control pair `wb`, `read_data`, `address_WB`, `write_register_mem`. Multi-cycle accesses are sequenced by a small FSM that stalls upstream stages and inserts bubbles toward writeback.

---
 rtl/mem_stage.sv | 175 +++++++++++++++++
 tb/tb_mem_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage of the five-stage MIPS pipeline. Performs word loads and
// stores against an internal data memory of configurable latency and drives the
// MEM/WB pipeline register. Multi-cycle accesses are held in a request register
// while a two-state FSM stalls upstream and feeds bubbles toward writeback.
module mem_stage #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  wb_mem,
  input  logic [1:0]  m_mem,
  input  logic [31:0] address_mem,
  input  logic [31:0] write_data_mem,
  input  logic [4:0]  write_register_in,
  output logic [1:0]  wb,
  output logic [31:0] read_data,
  output logic [31:0] address_WB,
  output logic [4:0]  write_register_mem,
  output logic        stall,
  output logic        misaligned
);

  localparam int unsigned ADDR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned CntInit = (LATENCY > 1) ? LATENCY - 2 : 0;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Request register: the access being serviced while BUSY.
  logic [31:0]       req_addr_q, req_addr_d;
  logic [31:0]       req_data_q, req_data_d;
  logic              req_read_q, req_read_d;
  logic              req_write_q, req_write_d;
  logic [1:0]        req_wb_q, req_wb_d;
  logic [4:0]        req_rd_q, req_rd_d;

  // MEM/WB pipeline register.
  logic [1:0]        wb_q, wb_d;
  logic [31:0]       read_data_q, read_data_d;
  logic [31:0]       address_wb_q, address_wb_d;
  logic [4:0]        rd_q, rd_d;
  logic              misaligned_q, misaligned_d;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] acc_idx;
  logic [31:0]       mem_rdata;
  logic [31:0]       mem_wdata;
  logic              mem_we;

  logic              in_access;
  logic              in_read;
  logic              in_write;
  logic              in_misaligned;

  // m_mem=11 counts as a read; the write half is suppressed.
  assign in_access     = |m_mem;
  assign in_read       = m_mem[1];
  assign in_write      = (m_mem == 2'b01);
  assign in_misaligned = in_access && (address_mem[1:0] != 2'b00);

  // Upper address bits are dropped so addresses wrap modulo DEPTH words.
  assign acc_idx   = (state_q == StBusy) ? req_addr_q[ADDR_W+1:2] : address_mem[ADDR_W+1:2];
  assign mem_rdata = mem[acc_idx];
  assign mem_wdata = (state_q == StBusy) ? req_data_q : write_data_mem;

  // Next-state, request capture and MEM/WB next values.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_addr_d   = req_addr_q;
    req_data_d   = req_data_q;
    req_read_d   = req_read_q;
    req_write_d  = req_write_q;
    req_wb_d     = req_wb_q;
    req_rd_d     = req_rd_q;
    wb_d         = wb_q;
    read_data_d  = read_data_q;
    address_wb_d = address_wb_q;
    rd_d         = rd_q;
    misaligned_d = 1'b0;
    mem_we       = 1'b0;

    case (state_q)
      StIdle: begin
        if (!in_access || in_misaligned || (LATENCY == 1)) begin
          wb_d         = wb_mem;
          address_wb_d = address_mem;
          rd_d         = write_register_in;
          read_data_d  = '0;
          if (in_misaligned) begin
            // Dropped access: flag it and send a bubble.
            misaligned_d = 1'b1;
            wb_d         = 2'b00;
          end else if (in_access) begin
            mem_we = in_write;
            if (in_read) read_data_d = mem_rdata;
          end
        end else begin
          req_addr_d  = address_mem;
          req_data_d  = write_data_mem;
          req_read_d  = in_read;
          req_write_d = in_write;
          req_wb_d    = wb_mem;
          req_rd_d    = write_register_in;
          cnt_d       = CNT_W'(CntInit);
          state_d     = StBusy;
          wb_d        = 2'b00;
        end
      end
      StBusy: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          wb_d  = 2'b00;
        end else begin
          mem_we       = req_write_q;
          wb_d         = req_wb_q;
          address_wb_d = req_addr_q;
          rd_d         = req_rd_q;
          read_data_d  = req_read_q ? mem_rdata : '0;
          state_d      = StIdle;
        end
      end
    endcase
  end

  // State, request and MEM/WB registers; reset aborts any pending access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      req_addr_q   <= '0;
      req_data_q   <= '0;
      req_read_q   <= 1'b0;
      req_write_q  <= 1'b0;
      req_wb_q     <= 2'b00;
      req_rd_q     <= '0;
      wb_q         <= 2'b00;
      read_data_q  <= '0;
      address_wb_q <= '0;
      rd_q         <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_addr_q   <= req_addr_d;
      req_data_q   <= req_data_d;
      req_read_q   <= req_read_d;
      req_write_q  <= req_write_d;
      req_wb_q     <= req_wb_d;
      req_rd_q     <= req_rd_d;
      wb_q         <= wb_d;
      read_data_q  <= read_data_d;
      address_wb_q <= address_wb_d;
      rd_q         <= rd_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Data memory write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[acc_idx] <= mem_wdata;
  end

  assign stall              = (state_q == StBusy);
  assign wb                 = wb_q;
  assign read_data          = read_data_q;
  assign address_WB         = address_wb_q;
  assign write_register_mem = rd_q;
  assign misaligned         = misaligned_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: two lanes (LATENCY=1 and LATENCY=3) each driven by
// directed and random instructions. The driver pushes expected MEM/WB entries
// computed from a word-array memory model; a monitor pops and compares them
// whenever the DUT presents an entry (wb!=00 or a misaligned pulse).
module tb_mem_stage;

  localparam int unsigned Depth = 256;

  typedef struct packed {
    logic        mis;
    logic        chk_data;
    logic [1:0]  wb;
    logic [31:0] data;
    logic [31:0] addr;
    logic [4:0]  rd;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit done [2];

  task automatic check(input int lane, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL lane%0d %s: got 0x%08h, expected 0x%08h", lane, name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int unsigned Lat = (g == 0) ? 1 : 3;

    logic        rst_n = 1'b1;
    logic [1:0]  wb_mem;
    logic [1:0]  m_mem;
    logic [31:0] address_mem;
    logic [31:0] write_data_mem;
    logic [4:0]  write_register_in;
    logic [1:0]  wb;
    logic [31:0] read_data;
    logic [31:0] address_WB;
    logic [4:0]  write_register_mem;
    logic        stall;
    logic        misaligned;

    logic [31:0] ref_mem [Depth];
    exp_t        q [$];

    mem_stage #(
      .DEPTH  (Depth),
      .LATENCY(Lat)
    ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .wb_mem            (wb_mem),
      .m_mem             (m_mem),
      .address_mem       (address_mem),
      .write_data_mem    (write_data_mem),
      .write_register_in (write_register_in),
      .wb                (wb),
      .read_data         (read_data),
      .address_WB        (address_WB),
      .write_register_mem(write_register_mem),
      .stall             (stall),
      .misaligned        (misaligned)
    );

    task automatic idle();
      wb_mem            = 2'b00;
      m_mem             = 2'b00;
      address_mem       = '0;
      write_data_mem    = '0;
      write_register_in = '0;
    endtask

    task automatic check_zero(input string tag);
      check(g, {tag, "_wb"}, 32'(wb), 32'd0);
      check(g, {tag, "_read_data"}, read_data, 32'd0);
      check(g, {tag, "_address_WB"}, address_WB, 32'd0);
      check(g, {tag, "_write_register_mem"}, 32'(write_register_mem), 32'd0);
      check(g, {tag, "_stall"}, 32'(stall), 32'd0);
      check(g, {tag, "_misaligned"}, 32'(misaligned), 32'd0);
    endtask

    // Present one instruction while the stage is free, update the model, and
    // wait until the stage is ready again, checking how long it stalled.
    task automatic issue(input logic [1:0] wbv, input logic [1:0] mv, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd);
      exp_t        e;
      int unsigned idx;
      int          n;
      bit          is_mis;
      idx    = (a / 4) % Depth;
      is_mis = (mv != 2'b00) && (a % 4 != 0);
      e      = '0;
      e.wb   = wbv;
      e.addr = a;
      e.rd   = rd;
      if (is_mis) begin
        e.mis = 1'b1;
        q.push_back(e);
      end else begin
        if (mv == 2'b00) begin
          e.chk_data = 1'b1;
          e.data     = '0;
        end else if (mv[1]) begin
          e.chk_data = 1'b1;
          e.data     = ref_mem[idx];
        end else begin
          ref_mem[idx] = d;
        end
        if (wbv != 2'b00) q.push_back(e);
      end
      wb_mem            = wbv;
      m_mem             = mv;
      address_mem       = a;
      write_data_mem    = d;
      write_register_in = rd;
      @(posedge clk);
      #1;
      n = 0;
      while (stall && n < 10) begin
        @(posedge clk);
        #1;
        n++;
      end
      check(g, "stall_cycles", n, (mv != 2'b00 && !is_mis) ? Lat - 1 : 0);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
      exp_t e;
      if (rst_n && (wb != 2'b00 || misaligned)) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL lane%0d unexpected_entry: got wb=%b misaligned=%b, expected no entry",
                   g, wb, misaligned);
        end else begin
          e = q.pop_front();
          check(g, "misaligned", 32'(misaligned), 32'(e.mis));
          check(g, "wb", 32'(wb), e.mis ? 32'd0 : 32'(e.wb));
          check(g, "address_WB", address_WB, e.addr);
          check(g, "write_register_mem", 32'(write_register_mem), 32'(e.rd));
          if (e.chk_data) check(g, "read_data", read_data, e.data);
        end
      end
    end

    initial begin
      logic [31:0] a;
      logic [1:0]  mv;
      int          r;
      idle();
      #1 rst_n = 1'b0;
      // Traffic presented while reset is held must not leak through.
      wb_mem      = 2'b11;
      m_mem       = 2'b10;
      address_mem = 32'h0000_0040;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      idle();
      rst_n = 1'b1;

      issue(2'b10, 2'b00, 32'h0000_1234, 32'h0, 5'd3);

      // Preload the words used by the random phase and the abort test.
      for (int i = 0; i < 16; i++) issue(2'b00, 2'b01, 32'(i * 4), $urandom, 5'd0);
      issue(2'b00, 2'b01, 32'h0000_0080, 32'h0BAD_CAFE, 5'd0);

      // Store then load the same word, then an ALU op that must wait its turn.
      issue(2'b00, 2'b01, 32'h0000_0040, 32'hDEAD_BEEF, 5'd0);
      issue(2'b11, 2'b10, 32'h0000_0040, 32'h0, 5'd5);
      issue(2'b10, 2'b00, 32'h0000_5555, 32'h0, 5'd7);

      // Misaligned store is dropped; the old word survives.
      issue(2'b01, 2'b01, 32'h0000_0042, 32'h1234_5678, 5'd6);
      issue(2'b11, 2'b10, 32'h0000_0040, 32'h0, 5'd8);

      // Word index wraps modulo Depth.
      issue(2'b00, 2'b01, 32'h0000_0400, 32'hCAFE_F00D, 5'd0);
      issue(2'b11, 2'b10, 32'h0000_0000, 32'h0, 5'd10);

      // m_mem=11 reads and must not write.
      issue(2'b11, 2'b11, 32'h0000_0004, 32'hFFFF_FFFF, 5'd11);
      issue(2'b11, 2'b10, 32'h0000_0004, 32'h0, 5'd12);

      for (int i = 0; i < 150; i++) begin
        r = $urandom_range(0, 9);
        a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 15) * 4);
        if (r < 3) begin
          mv = 2'b00;
          a  = $urandom;
        end else if (r < 6) mv = 2'b10;
        else if (r < 8) mv = 2'b01;
        else if (r == 8) mv = 2'b11;
        else begin
          mv = 2'($urandom_range(1, 3));
          a  = a | 32'($urandom_range(1, 3));
        end
        issue(2'($urandom_range(1, 3)), mv, a, $urandom, 5'($urandom_range(0, 31)));
      end

      // Reset in the second cycle of a store: the store must not land.
      @(negedge clk);
      wb_mem            = 2'b00;
      m_mem             = 2'b01;
      address_mem       = 32'h0000_0080;
      write_data_mem    = 32'h5A5A_5A5A;
      write_register_in = 5'd9;
      @(posedge clk);
      #1;
      idle();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      // With single-cycle access the store already completed.
      if (Lat == 1) ref_mem[32] = 32'h5A5A_5A5A;
      #1;
      check_zero("abort");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check(g, "stall_after_abort", 32'(stall), 32'd0);
      issue(2'b11, 2'b10, 32'h0000_0080, 32'h0, 5'd9);

      idle();
      repeat (4) @(negedge clk);
      check(g, "queue_drained", q.size(), 32'd0);
      done[g] = 1'b1;
    end
  end

  initial begin
    for (int c = 0; c < 30000; c++) begin
      if (done[0] && done[1]) break;
      @(posedge clk);
    end
    if (!(done[0] && done[1])) begin
      checks++;
      errors++;
      $display("FAIL timeout: lanes done %0d%0d, expected 11", done[0], done[1]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
